// File: rtl/jtag_shift_if.sv
// jtag_shift_if: host-side command/response channel of the JTAG shift engine
interface jtag_shift_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_len;
  logic [7:0] cmd_tdi;
  logic       cmd_tms;
  logic       cmd_tms_last;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_tdo;
  modport master (
    output cmd_valid, cmd_len, cmd_tdi, cmd_tms, cmd_tms_last, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_tdo
  );
  modport slave (
    input  cmd_valid, cmd_len, cmd_tdi, cmd_tms, cmd_tms_last, rsp_ready,
    output cmd_ready, rsp_valid, rsp_tdo
  );
endinterface

// File: rtl/jtag_shift_engine.sv
// jtag_shift_engine: byte-wide JTAG shifter driving FT_TCK/FT_TMS/FT_TDI and capturing FT_TDO.
// TDO is taken from a 2-flop synchroniser on the first clk of each TCK high phase; targets need two clk of extra setup.
module jtag_shift_engine #(
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  jtag_shift_if.slave bus,
  output logic        FT_TCK,
  output logic        FT_TMS,
  output logic        FT_TDI,
  input  logic        FT_TDO
);
  typedef enum logic [1:0] {IDLE, LOW, HIGH, RESP} state_t;
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  state_t     state_q, state_d;
  logic [7:0] div_q, div_d, tx_q, tx_d, rx_q, rx_d, rsp_tdo_q, rsp_tdo_d;
  logic [2:0] cnt_q, cnt_d, len_q, len_d, cnt_nx;
  logic       tms_q, tms_d, tml_q, tml_d;
  logic       tck_q, tck_d, pin_tms_q, pin_tms_d, pin_tdi_q, pin_tdi_d;
  logic       rdy_q, rdy_d, rsp_valid_q, rsp_valid_d;
  logic       sync1_q, sync2_q, div_end;
  assign div_end = div_q == DIV_LAST;
  assign cnt_nx  = cnt_q - 3'd1;
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    rsp_tdo_d   = rsp_tdo_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    tms_d       = tms_q;
    tml_d       = tml_q;
    tck_d       = tck_q;
    pin_tms_d   = pin_tms_q;
    pin_tdi_d   = pin_tdi_q;
    rsp_valid_d = rsp_valid_q;
    case (state_q)
      IDLE: if (bus.cmd_valid && rdy_q) begin
        state_d   = LOW;
        div_d     = '0;
        tx_d      = bus.cmd_tdi;
        rx_d      = '0;
        cnt_d     = bus.cmd_len;
        len_d     = bus.cmd_len;
        tms_d     = bus.cmd_tms;
        tml_d     = bus.cmd_tms_last;
        tck_d     = 1'b0;
        pin_tdi_d = bus.cmd_tdi[0];
        pin_tms_d = bus.cmd_tms ^ (bus.cmd_tms_last && bus.cmd_len == 3'd0);
      end
      LOW: begin
        div_d   = div_end ? 8'd0 : div_q + 8'd1;
        tck_d   = div_end;
        state_d = div_end ? HIGH : LOW;
      end
      HIGH: begin
        div_d = div_end ? 8'd0 : div_q + 8'd1;
        rx_d  = div_q == 8'd0 ? {sync2_q, rx_q[7:1]} : rx_q;
        if (div_end) begin
          tck_d   = 1'b0;
          state_d = cnt_q == 3'd0 ? RESP : LOW;
          if (cnt_q != 3'd0) begin
            cnt_d     = cnt_nx;
            tx_d      = tx_q >> 1;
            pin_tdi_d = tx_q[1];
            pin_tms_d = tms_q ^ (tml_q && cnt_nx == 3'd0);
          end
        end
      end
      RESP: begin
        // Right-align the capture: bit i is the TDO seen on TCK pulse i.
        rsp_tdo_d   = rsp_valid_q ? rsp_tdo_q : rx_q >> (3'd7 - len_q);
        rsp_valid_d = !(rsp_valid_q && bus.rsp_ready);
        state_d     = rsp_valid_q && bus.rsp_ready ? IDLE : RESP;
      end
      default: state_d = IDLE;
    endcase
    rdy_d = state_d == IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      div_q       <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      rsp_tdo_q   <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      tms_q       <= 1'b0;
      tml_q       <= 1'b0;
      tck_q       <= 1'b0;
      pin_tms_q   <= 1'b1;
      pin_tdi_q   <= 1'b0;
      rdy_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      rsp_tdo_q   <= rsp_tdo_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      tms_q       <= tms_d;
      tml_q       <= tml_d;
      tck_q       <= tck_d;
      pin_tms_q   <= pin_tms_d;
      pin_tdi_q   <= pin_tdi_d;
      rdy_q       <= rdy_d;
      rsp_valid_q <= rsp_valid_d;
      sync1_q     <= FT_TDO;
      sync2_q     <= sync1_q;
    end
  end
  assign bus.cmd_ready = rdy_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_tdo   = rsp_tdo_q;
  assign FT_TCK        = tck_q;
  assign FT_TMS        = pin_tms_q;
  assign FT_TDI        = pin_tdi_q;
endmodule

// File: tb/tb_jtag_shift_engine.sv
// tb_jtag_shift_engine: scoreboard bench; CLK_DIV=2 engine under random and directed traffic, CLK_DIV=1 engine directed.
module tb_jtag_shift_engine;
  logic clk, rst;
  logic tck, tms, tdi, tdo, tck1, tms1, tdi1, tdo1;
  logic [1:0] tdo_mode;
  jtag_shift_if bus();
  jtag_shift_if bus1();
  jtag_shift_engine #(.CLK_DIV(2)) dut (.clk(clk), .rst(rst), .bus(bus), .FT_TCK(tck), .FT_TMS(tms), .FT_TDI(tdi), .FT_TDO(tdo));
  jtag_shift_engine #(.CLK_DIV(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1), .FT_TCK(tck1), .FT_TMS(tms1), .FT_TDI(tdi1), .FT_TDO(tdo1));
  // tdo_mode: 0 = TDO low, 1 = TDO high, 2 = TDO looped back from TDI
  assign tdo = tdo_mode == 2'd2 ? tdi : tdo_mode[0];
  int n_checks = 0, n_fail = 0;
  logic [7:0] exp_q[$];
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask
  // Loopback sees each TDI bit because it is stable for more than the two synchroniser cycles before sampling.
  function automatic logic [7:0] model(input logic [2:0] l, input logic [7:0] d, input logic [1:0] mode);
    logic [8:0] m9;
    m9 = (9'd1 << (l + 4'd1)) - 9'd1;
    return mode == 2'd2 ? d & m9[7:0] : mode == 2'd1 ? m9[7:0] : 8'h00;
  endfunction
  // Monitor: pin protocol per TCK edge, latency, and response scoreboard
  bit busy = 0, seen = 0, b2b = 0, prev_tck = 0, cur_tms = 0, cur_tml = 0;
  int cyc = 0, run = 0, rises = 0, neg_cnt = 0, hs_at = 0, cur_len = 0;
  logic [7:0] cur_tdi = 0;
  initial begin
    int b;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      neg_cnt++;
      if (rst) begin
        busy = 0; seen = 0; run = 0; prev_tck = 0;
      end else begin
        if (busy && !seen && bus.rsp_valid) begin
          seen = 1;
          check("latency", cyc, 4 * (cur_len + 1) + 1);
          check("tck_pulses", rises, cur_len + 1);
        end
        if (busy) cyc++;
        if (tck != prev_tck) begin
          if (busy) check("tck_half", run, 2);
          if (tck && busy) rises++;
          run = 1;
        end else run++;
        prev_tck = tck;
        if (busy && !seen) begin
          b = tck ? rises - 1 : rises;
          b = b > cur_len ? cur_len : b < 0 ? 0 : b;
          check("ft_tms", tms, (b == cur_len && cur_tml) ? !cur_tms : cur_tms);
          check("ft_tdi", tdi, cur_tdi[b[2:0]]);
        end
        if (bus.rsp_valid && bus.rsp_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL stale_rsp: got response 0x%0h expected none", bus.rsp_tdo);
          end else begin
            e = exp_q.pop_front();
            check("rsp_tdo", bus.rsp_tdo, e);
          end
          hs_at = neg_cnt;
          busy = 0;
        end
        if (bus.cmd_valid && bus.cmd_ready) begin
          if (b2b) check("b2b_gap", neg_cnt - hs_at, 1);
          busy = 1; seen = 0; cyc = 0; run = 0; rises = 0;
          cur_len = int'(bus.cmd_len); cur_tdi = bus.cmd_tdi; cur_tms = bus.cmd_tms; cur_tml = bus.cmd_tms_last;
        end
      end
    end
  end
  task automatic send(input logic [2:0] l, input logic [7:0] d, input logic m, input logic ml, input logic [1:0] mode, output int w);
    bus.cmd_len = l; bus.cmd_tdi = d; bus.cmd_tms = m; bus.cmd_tms_last = ml; tdo_mode = mode;
    bus.cmd_valid = 1; w = 0;
    while (!bus.cmd_ready && w < 200) begin @(posedge clk); #1; w++; end
    if (!bus.cmd_ready) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: cmd_ready got 0 expected 1");
    end else exp_q.push_back(model(l, d, mode));
    @(posedge clk); #1;
    bus.cmd_valid = 0;
  endtask
  task automatic drain(input bit rnd);
    int w = 0;
    while (exp_q.size() != 0 && w < 400) begin
      bus.rsp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1; w++;
    end
    bus.rsp_ready = 1;
    check("drain_pending", exp_q.size(), 0);
  endtask
  task automatic run1(input logic [2:0] l, input logic [7:0] d, input logic bt);
    int cyc1 = 0, hi = 0, w = 0;
    logic [8:0] m9;
    m9 = (9'd1 << (l + 4'd1)) - 9'd1;
    tdo1 = bt; bus1.cmd_len = l; bus1.cmd_tdi = d; bus1.cmd_tms = 0; bus1.cmd_tms_last = 0; bus1.cmd_valid = 1;
    while (!bus1.cmd_ready && w < 50) begin @(posedge clk); #1; w++; end
    check("d1_ready", bus1.cmd_ready, 1);
    @(posedge clk); #1;
    bus1.cmd_valid = 0;
    while (!bus1.rsp_valid && cyc1 < 100) begin
      if (tck1) begin check("d1_tdi", tdi1, d[hi[2:0]]); hi++; end
      @(posedge clk); #1; cyc1++;
    end
    check("d1_latency", cyc1, 2 * (int'(l) + 1) + 1);
    check("d1_pulses", hi, int'(l) + 1);
    check("d1_rsp", bus1.rsp_tdo, bt ? m9[7:0] : 8'h00);
    @(posedge clk); #1;
  endtask
  initial begin
    int w, cnt;
    bit pt;
    rst = 1; tdo_mode = 0; tdo1 = 0;
    bus.cmd_valid = 0; bus.cmd_len = 0; bus.cmd_tdi = 0; bus.cmd_tms = 0; bus.cmd_tms_last = 0; bus.rsp_ready = 1;
    bus1.cmd_valid = 0; bus1.cmd_len = 0; bus1.cmd_tdi = 0; bus1.cmd_tms = 0; bus1.cmd_tms_last = 0; bus1.rsp_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tck", tck, 0); check("rst_tms", tms, 1); check("rst_tdi", tdi, 0);
    check("rst_ready", bus.cmd_ready, 0); check("rst_rsp_valid", bus.rsp_valid, 0); check("rst_rsp_tdo", bus.rsp_tdo, 0);
    rst = 0;
    @(posedge clk); #1;
    check("ready_after_rst", bus.cmd_ready, 1);
    run1(3'd0, 8'h01, 1'b0);
    run1(3'd7, 8'($urandom), 1'b1);
    run1(3'd3, 8'($urandom), 1'b0);
    send(3'd7, 8'hA5, 0, 0, 2'd2, w); drain(0);
    send(3'd4, 8'h1F, 0, 1, 2'd1, w); drain(0);
    bus.rsp_ready = 0;
    send(3'd5, 8'h5A, 1, 0, 2'd1, w);
    w = 0;
    while (!bus.rsp_valid && w < 100) begin @(posedge clk); #1; w++; end
    check("bp_valid_seen", bus.rsp_valid, 1);
    bus.cmd_valid = 1; bus.cmd_tdi = 8'hFF; bus.cmd_len = 3'd7;
    repeat (10) begin
      @(posedge clk); #1;
      check("bp_valid", bus.rsp_valid, 1); check("bp_data", bus.rsp_tdo, 8'h3F); check("bp_ready", bus.cmd_ready, 0);
    end
    bus.rsp_ready = 1;
    @(posedge clk); #1;
    check("ready_after_rsp", bus.cmd_ready, 1);
    check("valid_after_rsp", bus.rsp_valid, 0);
    send(3'd2, 8'h06, 0, 1, 2'd2, w);
    check("accept_next_cycle", w, 0);
    drain(0);
    send(3'd7, 8'h3C, 0, 0, 2'd2, w);
    b2b = 1;
    send(3'd7, 8'hC3, 0, 0, 2'd2, w);
    drain(0);
    b2b = 0;
    for (int i = 0; i < 30; i++) begin
      send(3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), w);
      drain(1);
    end
    send(3'd7, 8'h96, 0, 0, 2'd2, w);
    cnt = 0; w = 0; pt = 0;
    while (cnt < 3 && w < 200) begin
      @(posedge clk); #1;
      if (tck && !pt) cnt++;
      pt = tck; w++;
    end
    check("reach_3rd_high", cnt, 3);
    #2 rst = 1;
    #1;
    check("mid_rst_tck", tck, 0); check("mid_rst_tms", tms, 1); check("mid_rst_tdi", tdi, 0);
    check("mid_rst_rsp_valid", bus.rsp_valid, 0); check("mid_rst_ready", bus.cmd_ready, 0);
    exp_q.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 0;
    check("ready_at_release", bus.cmd_ready, 0);
    @(posedge clk); #1;
    check("ready_after_release", bus.cmd_ready, 1);
    repeat (40) begin
      @(posedge clk); #1;
      check("no_stale_rsp", bus.rsp_valid, 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
